wm_plant_model: RTL



---
 rtl/wm_plant_model.sv | 118 +++++++++++
 1 files changed

// File: rtl/wm_plant_model.sv
// Behavioural washing-machine drum plant: turns controller actuator commands
// into level, dispenser, wash-timer and spin-timer sensor responses.
module wm_plant_model #(
    parameter int LEVEL_MAX   = 8,
    parameter int DRAIN_STEP  = 2,
    parameter int DET_CYCLES  = 3,
    parameter int WASH_CYCLES = 16,
    parameter int SPIN_CYCLES = 12,
    localparam int LW = $clog2(LEVEL_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          door_lock,
    input  logic          motor_on,
    input  logic          fill_valve_on,
    input  logic          drain_valve_on,
    input  logic          soap_wash,
    output logic          filled,
    output logic          drained,
    output logic          detergent_added,
    output logic          cycle_timeout,
    output logic          spin_timeout,
    output logic [LW-1:0] water_level,
    output logic [1:0]    fault
);

    localparam int DW = $clog2(DET_CYCLES + 1);
    localparam int WW = $clog2(WASH_CYCLES + 1);
    localparam int SW = $clog2(SPIN_CYCLES + 1);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(LEVEL_MAX);
    localparam logic [LW-1:0] LEVEL_STEP = LW'(DRAIN_STEP);
    localparam logic [DW-1:0] DET_DONE   = DW'(DET_CYCLES);
    localparam logic [WW-1:0] WASH_DONE  = WW'(WASH_CYCLES);
    localparam logic [SW-1:0] SPIN_DONE  = SW'(SPIN_CYCLES);

    logic [LW-1:0] level,    level_nxt;
    logic [DW-1:0] det_cnt,  det_cnt_nxt;
    logic [WW-1:0] wash_cnt, wash_cnt_nxt;
    logic [SW-1:0] spin_cnt, spin_cnt_nxt;
    logic          cycle_to, cycle_to_nxt;
    logic          spin_to,  spin_to_nxt;
    logic [1:0]    fault_q,  fault_nxt;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        level_nxt    = level;
        det_cnt_nxt  = det_cnt;
        wash_cnt_nxt = wash_cnt;
        spin_cnt_nxt = spin_cnt;
        cycle_to_nxt = cycle_to;
        spin_to_nxt  = spin_to;
        fault_nxt    = fault_q;

        if (fill_valve_on && !drain_valve_on) begin
            if (level != LEVEL_FULL) level_nxt = level + LW'(1);
        end else if (drain_valve_on && !fill_valve_on) begin
            level_nxt = (32'(level) < DRAIN_STEP) ? '0 : level - LEVEL_STEP;
        end else if (fill_valve_on && drain_valve_on) begin
            fault_nxt[0] = 1'b1;
        end

        if (!door_lock && (motor_on || fill_valve_on || drain_valve_on))
            fault_nxt[1] = 1'b1;

        if (!soap_wash)
            det_cnt_nxt = '0;
        else if (det_cnt != DET_DONE)
            det_cnt_nxt = det_cnt + DW'(1);

        // A fill starts a new batch (wash or rinse), so both timers re-arm.
        if (fill_valve_on) begin
            wash_cnt_nxt = '0;
            spin_cnt_nxt = '0;
            cycle_to_nxt = 1'b0;
            spin_to_nxt  = 1'b0;
        end else begin
            if (motor_on && level == LEVEL_FULL && wash_cnt != WASH_DONE) begin
                wash_cnt_nxt = wash_cnt + WW'(1);
                if (wash_cnt_nxt == WASH_DONE) cycle_to_nxt = 1'b1;
            end
            if (level == '0 && (drain_valve_on || motor_on) && spin_cnt != SPIN_DONE) begin
                spin_cnt_nxt = spin_cnt + SW'(1);
                if (spin_cnt_nxt == SPIN_DONE) spin_to_nxt = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            level    <= '0;
            det_cnt  <= '0;
            wash_cnt <= '0;
            spin_cnt <= '0;
            cycle_to <= 1'b0;
            spin_to  <= 1'b0;
            fault_q  <= 2'b00;
        end else begin
            level    <= level_nxt;
            det_cnt  <= det_cnt_nxt;
            wash_cnt <= wash_cnt_nxt;
            spin_cnt <= spin_cnt_nxt;
            cycle_to <= cycle_to_nxt;
            spin_to  <= spin_to_nxt;
            fault_q  <= fault_nxt;
        end
    end

    assign water_level     = level;
    assign filled          = (level == LEVEL_FULL);
    assign drained         = (level == '0);
    assign detergent_added = (det_cnt == DET_DONE);
    assign cycle_timeout   = cycle_to;
    assign spin_timeout    = spin_to;
    assign fault           = fault_q;

endmodule
